score_bcd_arbiter: RTL and testbench

SCORE_BCD_ARBITER -- requirements
Module: score_bcd_arbiter

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_dabble_step.sv | 21 ++
 rtl/score_bcd_arbiter.sv | 103 ++++++++++
 tb/tb_score_bcd_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and sizing for the score BCD arbiter.
package bcd_pkg;

  localparam int BIN_W       = 8;
  localparam int DIGITS      = 3;
  localparam int SHIFT_COUNT = 8;
  localparam int ACC_W       = 4 * DIGITS;
  localparam int CNT_W       = $clog2(SHIFT_COUNT);

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/bcd_dabble_step.sv
// One shift-add-3 iteration: correct each digit >= 5, then shift in one data bit.
module bcd_dabble_step
  import bcd_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  input  logic             bit_in,
  output logic [ACC_W-1:0] acc_next
);

  logic [ACC_W-1:0] adj;

  // Add-3 correction per digit followed by a one-bit left shift.
  always_comb begin
    adj = acc;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    acc_next = {adj[ACC_W-2:0], bit_in};
  end

endmodule

// File: rtl/score_bcd_arbiter.sv
// Two requesters sharing one iterative binary-to-BCD converter, round-robin arbitrated.
module score_bcd_arbiter
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [BIN_W-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [BIN_W-1:0] req1_data,
  output logic             req1_ready,
  output bcd_digit_t       hundreds0,
  output bcd_digit_t       tens0,
  output bcd_digit_t       ones0,
  output bcd_digit_t       hundreds1,
  output bcd_digit_t       tens1,
  output bcd_digit_t       ones1,
  output logic             done0,
  output logic             done1,
  output logic             busy
);

  state_t           state, state_next;
  logic             last_grant;
  logic             grant_sel;
  logic             cur;
  logic             handshake;
  logic [BIN_W-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc, acc_next;

  bcd_dabble_step u_step (
    .acc      (acc),
    .bit_in   (shreg[cnt]),
    .acc_next (acc_next)
  );

  // Round-robin grant; ready only in IDLE and only toward the granted, valid requester.
  always_comb begin
    grant_sel = 1'b0;
    if (req0_valid && req1_valid) grant_sel = ~last_grant;
    else if (req1_valid)          grant_sel = 1'b1;
    req0_ready = (state == IDLE) && req0_valid && !grant_sel;
    req1_ready = (state == IDLE) && req1_valid &&  grant_sel;
    handshake  = req0_ready || req1_ready;
  end

  // Next-state and status outputs.
  always_comb begin
    state_next = state;
    done0      = 1'b0;
    done1      = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:  if (handshake) state_next = SHIFT;
      SHIFT: if (cnt == '0) state_next = DONE;
      DONE: begin
        state_next = IDLE;
        done0      = !cur;
        done1      = cur;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Capture, iterate and write back the result of the latched requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      cur        <= 1'b0;
      shreg      <= '0;
      cnt        <= '0;
      acc        <= '0;
      hundreds0  <= '0;
      tens0      <= '0;
      ones0      <= '0;
      hundreds1  <= '0;
      tens1      <= '0;
      ones1      <= '0;
    end else if (handshake) begin
      shreg      <= grant_sel ? req1_data : req0_data;
      cur        <= grant_sel;
      last_grant <= grant_sel;
      acc        <= '0;
      cnt        <= CNT_W'(SHIFT_COUNT - 1);
    end else if (state == SHIFT) begin
      acc <= acc_next;
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        if (cur) {hundreds1, tens1, ones1} <= acc_next;
        else     {hundreds0, tens0, ones0} <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_score_bcd_arbiter.sv
// Directed self-checking bench for score_bcd_arbiter.
module tb_score_bcd_arbiter;

  logic       clk;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic [3:0] hundreds0, tens0, ones0, hundreds1, tens1, ones1;
  logic       done0, done1, busy;

  int n_cmp = 0;
  int n_bad = 0;

  score_bcd_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .hundreds0  (hundreds0),
    .tens0      (tens0),
    .ones0      (ones0),
    .hundreds1  (hundreds1),
    .tens1      (tens1),
    .ones1      (ones1),
    .done0      (done0),
    .done1      (done1),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] bcd_model(input logic [7:0] v);
    int unsigned x;
    x = v;
    return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk12(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Single-requester conversion starting in an IDLE cycle; checks the whole timeline.
  task automatic run_one(input logic who, input logic [7:0] val);
    logic [11:0] other_before;
    other_before = who ? {hundreds0, tens0, ones0} : {hundreds1, tens1, ones1};
    if (who) begin req1_data = val; req1_valid = 1'b1; end
    else     begin req0_data = val; req0_valid = 1'b1; end
    #1;
    chk1("ready_granted", who ? req1_ready : req0_ready, 1'b1);
    chk1("ready_other",   who ? req0_ready : req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk1("busy_shift", busy, 1'b1);
      chk1("no_done_shift", done0 | done1, 1'b0);
      tick();
    end
    chk1("done_granted", who ? done1 : done0, 1'b1);
    chk1("done_other",   who ? done0 : done1, 1'b0);
    chk1("busy_done", busy, 1'b1);
    chk12("digits", who ? {hundreds1, tens1, ones1} : {hundreds0, tens0, ones0}, bcd_model(val));
    chk12("other_unchanged", who ? {hundreds0, tens0, ones0} : {hundreds1, tens1, ones1}, other_before);
    tick();
    chk1("busy_idle", busy, 1'b0);
    chk1("done_cleared", done0 | done1, 1'b0);
  endtask

  initial begin
    int nhs;
    int hcyc[6];
    logic hwho[6];

    reset      = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = '0;
    req1_data  = '0;

    // Reset values.
    tick();
    tick();
    chk12("rst_digits0", {hundreds0, tens0, ones0}, 12'h000);
    chk12("rst_digits1", {hundreds1, tens1, ones1}, 12'h000);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done0 | done1, 1'b0);
    chk1("rst_ready_idle", req0_ready | req1_ready, 1'b0);
    reset = 1'b0;

    // req0 = 0 in the first cycle out of reset, then req0 = 255.
    run_one(1'b0, 8'd0);
    chk12("r0_zero_req1_still_0", {hundreds1, tens1, ones1}, 12'h000);
    run_one(1'b0, 8'd255);
    chk12("r0_255", {hundreds0, tens0, ones0}, 12'h255);

    // Simultaneous 42 / 99 after reset: req0 wins, req1 waits with ready low.
    do_reset();
    req0_data = 8'd42; req1_data = 8'd99;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk1("tie_ready0", req0_ready, 1'b1);
    chk1("tie_ready1", req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk1("tie_wait_ready1", req1_ready, 1'b0);
      tick();
    end
    chk1("tie_done0", done0, 1'b1);
    chk1("tie_wait_ready1_done", req1_ready, 1'b0);
    chk12("tie_digits0", {hundreds0, tens0, ones0}, 12'h042);
    tick();
    chk1("tie_ready1_n10", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    chk1("tie_done1", done1, 1'b1);
    chk12("tie_digits1", {hundreds1, tens1, ones1}, 12'h099);
    chk12("tie_digits0_kept", {hundreds0, tens0, ones0}, 12'h042);
    tick();

    // Both valid continuously: alternating grants, 10 cycles apart.
    req0_data = 8'd42; req1_data = 8'd99;
    req0_valid = 1'b1; req1_valid = 1'b1;
    nhs = 0;
    for (int c = 0; c < 80 && nhs < 6; c++) begin
      #1;
      if (req0_ready)      begin hwho[nhs] = 1'b0; hcyc[nhs] = c; nhs++; end
      else if (req1_ready) begin hwho[nhs] = 1'b1; hcyc[nhs] = c; nhs++; end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk12("rr_count", 12'(nhs), 12'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < nhs) begin
        chk1("rr_order", hwho[i], (i % 2) == 1);
        if (i > 0) chk12("rr_spacing", 12'(hcyc[i] - hcyc[i-1]), 12'd10);
      end
    end
    for (int k = 1; k <= 8; k++) tick();
    chk1("rr_last_done1", done1, 1'b1);
    chk12("rr_last_digits1", {hundreds1, tens1, ones1}, 12'h099);
    tick();

    // Reset during a req1 = 200 conversion.
    req1_data = 8'd200; req1_valid = 1'b1;
    #1;
    chk1("abort_ready1", req1_ready, 1'b1);
    tick();
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done0 | done1, 1'b0);
    chk12("abort_digits0", {hundreds0, tens0, ones0}, 12'h000);
    chk12("abort_digits1", {hundreds1, tens1, ones1}, 12'h000);
    chk1("abort_ready_after_reset", req1_ready, 1'b1);
    req1_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk1("abort_no_done1", done1, 1'b0);
      chk12("abort_digits1_hold", {hundreds1, tens1, ones1}, 12'h000);
    end

    // Full sweep, alternating requesters.
    for (int v = 0; v < 256; v++) run_one(1'(v % 2), 8'(v));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
